// File: rtl/fib_stream_gen_if.sv
// Output stream bundle for fib_stream_gen: valid/ready handshake plus the term,
// its sequence position and the sticky overflow flag.
interface fib_stream_gen_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] fib_out;
  logic [IDX_W-1:0] index;
  logic             overflow;

  modport master (
    output out_valid,
    output fib_out,
    output index,
    output overflow,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  fib_out,
    input  index,
    input  overflow,
    output out_ready
  );
endinterface

// File: rtl/fib_stream_gen.sv
// Seedable Fibonacci term source with step/run advance and valid/ready output.
// Define FIB_SAT_EN to saturate B at all-ones on carry instead of wrapping.
//
// state  | meaning
// IDLE   | no term offered, waiting for a step edge or prescaler tick
// EMIT   | term A offered on fib_out, waiting for the consumer handshake
module fib_stream_gen #(
  parameter int WIDTH    = 16,
  parameter int SEED_W   = 4,
  parameter int IDX_W    = 8,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEED_W-1:0] seed,
  input  logic              set_a,
  input  logic              set_b,
  input  logic              step,
  input  logic              run,
  fib_stream_gen_if.master  out
);
  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [0:0] {S_IDLE, S_EMIT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             ovf_q;
  logic             pend_q;
  logic [PRE_W-1:0] pre_q;
  logic             set_a_q;
  logic             set_b_q;
  logic             step_q;

  logic             ev_a;
  logic             ev_b;
  logic             load;
  logic             tick;
  logic             req;
  logic             hs;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] next_b;
  logic [WIDTH-1:0] seed_ext;

  assign ev_a     = set_a & ~set_a_q;
  assign ev_b     = set_b & ~set_b_q;
  assign load     = ev_a | ev_b;
  assign tick     = run && (pre_q == PRE_W'(TICK_DIV - 1));
  assign req      = (step & ~step_q) | tick;
  assign hs       = valid_q & out.out_ready;
  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign carry    = sum[WIDTH];
  assign seed_ext = WIDTH'(seed);

`ifdef FIB_SAT_EN
  assign next_b = carry ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
  assign next_b = sum[WIDTH-1:0];
`endif

  assign out.out_valid = valid_q;
  assign out.fib_out   = a_q;
  assign out.index     = idx_q;
  assign out.overflow  = ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      set_a_q <= 1'b0;
      set_b_q <= 1'b0;
      step_q  <= 1'b0;
      pre_q   <= '0;
    end else begin
      set_a_q <= set_a;
      set_b_q <= set_b;
      step_q  <= step;
      if (!run || tick) pre_q <= '0;
      else              pre_q <= pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= WIDTH'(1);
      idx_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else if (load) begin
      // A load also swallows any coincident handshake: the sequence restarts.
      if (ev_a) a_q <= seed_ext;
      if (ev_b) b_q <= seed_ext;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q <= S_EMIT;
            valid_q <= 1'b1;
          end
        end
        S_EMIT: begin
          if (hs) begin
            a_q   <= b_q;
            b_q   <= next_b;
            idx_q <= idx_q + IDX_W'(1);
            if (carry) ovf_q <= 1'b1;
            if (pend_q || req) begin
              pend_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
            end
          end else if (req) begin
            pend_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fib_stream_gen.sv
// Directed bench for fib_stream_gen at WIDTH=8, TICK_DIV=4 with hand-computed terms.
module tb_fib_stream_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] seed = '0;
  logic       set_a = 1'b0;
  logic       set_b = 1'b0;
  logic       step = 1'b0;
  logic       run = 1'b0;

  int errors = 0;
  int checks = 0;

  fib_stream_gen_if #(.WIDTH(8), .IDX_W(8)) bus ();

  fib_stream_gen #(
    .WIDTH(8), .SEED_W(4), .IDX_W(8), .TICK_DIV(4)
  ) dut (
    .clk(clk), .reset(reset), .seed(seed), .set_a(set_a), .set_b(set_b),
    .step(step), .run(run), .out(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    seed = '0; set_a = 1'b0; set_b = 1'b0; step = 1'b0; run = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", bus.out_valid); end
    checks++;
    if (bus.fib_out !== 8'd0) begin errors++; $display("FAIL reset_fib_out: got %0d expected 0", bus.fib_out); end
    checks++;
    if (bus.index !== 8'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", bus.index); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0d expected 0", bus.overflow); end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %0d expected 0", bus.out_valid); end
  endtask

  task automatic test_sequence();
    int exp_seq [13] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};
`ifdef FIB_SAT_EN
    int exp_tail [3] = '{233, 255, 255};
    int n_tail = 3;
`else
    int exp_tail [3] = '{233, 121, 0};
    int n_tail = 2;
`endif
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step = 1'b1;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.fib_out !== 8'(exp_seq[i]) || bus.index !== 8'(i)) begin
        errors++;
        $display("FAIL seq_term[%0d]: got valid=%0d term=%0d idx=%0d expected valid=1 term=%0d idx=%0d",
                 i, bus.out_valid, bus.fib_out, bus.index, exp_seq[i], i);
      end
      checks++;
      if (bus.overflow !== 1'b0) begin errors++; $display("FAIL seq_ovf_pre[%0d]: got %0d expected 0", i, bus.overflow); end
      step = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL seq_idle[%0d]: got valid=%0d expected 0", i, bus.out_valid); end
      checks++;
      if (bus.overflow !== (i == 12)) begin errors++; $display("FAIL seq_ovf_post[%0d]: got %0d expected %0d", i, bus.overflow, i == 12); end
    end
    for (int i = 0; i < n_tail; i++) begin
      step = 1'b1;
      tick();
      checks++;
      if (bus.fib_out !== 8'(exp_tail[i]) || bus.index !== 8'(13 + i)) begin
        errors++;
        $display("FAIL tail_term[%0d]: got term=%0d idx=%0d expected term=%0d idx=%0d",
                 i, bus.fib_out, bus.index, exp_tail[i], 13 + i);
      end
      step = 1'b0;
      tick();
      checks++;
      if (bus.overflow !== 1'b1) begin errors++; $display("FAIL tail_ovf[%0d]: got %0d expected 1", i, bus.overflow); end
    end
  endtask

  task automatic test_load_handshake();
    bus.out_ready = 1'b1;
    step = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL lhs_setup: got valid=%0d ovf=%0d expected valid=1 ovf=1", bus.out_valid, bus.overflow);
    end
    step = 1'b0;
    seed = 4'd9;
    set_a = 1'b1;
    tick();
    checks++;
    if (bus.fib_out !== 8'd9) begin errors++; $display("FAIL lhs_a: got %0d expected 9", bus.fib_out); end
    checks++;
    if (bus.index !== 8'd0) begin errors++; $display("FAIL lhs_index: got %0d expected 0", bus.index); end
    checks++;
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL lhs_ovf: got %0d expected 0", bus.overflow); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lhs_valid: got %0d expected 0", bus.out_valid); end
    set_a = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fib_out !== 8'd9) begin
      errors++;
      $display("FAIL lhs_hold: got valid=%0d term=%0d expected valid=0 term=9", bus.out_valid, bus.fib_out);
    end
  endtask

  task automatic test_seed();
    int exp_seq [5] = '{5, 3, 8, 11, 19};
    bus.out_ready = 1'b1;
    seed = 4'd5;
    set_a = 1'b1;
    tick();
    set_a = 1'b0;
    seed = 4'd3;
    set_b = 1'b1;
    tick();
    set_b = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      step = 1'b1;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.fib_out !== 8'(exp_seq[i]) || bus.index !== 8'(i)) begin
        errors++;
        $display("FAIL seed_term[%0d]: got valid=%0d term=%0d idx=%0d expected valid=1 term=%0d idx=%0d",
                 i, bus.out_valid, bus.fib_out, bus.index, exp_seq[i], i);
      end
      step = 1'b0;
      tick();
    end
  endtask

  task automatic test_back_pressure();
    apply_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.fib_out !== 8'd0) begin
      errors++;
      $display("FAIL bp_hold: got valid=%0d term=%0d expected valid=1 term=0", bus.out_valid, bus.fib_out);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.fib_out !== 8'd1 || bus.index !== 8'd1) begin
      errors++;
      $display("FAIL bp_second: got valid=%0d term=%0d idx=%0d expected valid=1 term=1 idx=1",
               bus.out_valid, bus.fib_out, bus.index);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.index !== 8'd2) begin
      errors++;
      $display("FAIL bp_done: got valid=%0d idx=%0d expected valid=0 idx=2", bus.out_valid, bus.index);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.index !== 8'd2) begin
      errors++;
      $display("FAIL bp_idle: got valid=%0d idx=%0d expected valid=0 idx=2", bus.out_valid, bus.index);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    bus.out_ready = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ar_setup: got valid=%0d expected 1", bus.out_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.index !== 8'd0 || bus.fib_out !== 8'd0) begin
      errors++;
      $display("FAIL ar_drop: got valid=%0d term=%0d idx=%0d expected all 0", bus.out_valid, bus.fib_out, bus.index);
    end
    #1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_run();
    int exp_run [4] = '{0, 1, 1, 2};
    int seen = 0;
    apply_reset();
    bus.out_ready = 1'b1;
    run = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        checks++;
        if ((c % 4) != 0 || seen > 3) begin
          errors++;
          $display("FAIL run_period: got term at cycle %0d expected only at multiples of 4", c);
        end else if (bus.fib_out !== 8'(exp_run[seen])) begin
          errors++;
          $display("FAIL run_term[%0d]: got %0d expected %0d", seen, bus.fib_out, exp_run[seen]);
        end
        seen++;
      end
    end
    checks++;
    if (seen != 4) begin errors++; $display("FAIL run_count: got %0d expected 4", seen); end
    tick();
    tick();
    run = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL run_stop: got %0d terms expected 0", seen); end
    checks++;
    if (dut.pre_q !== '0) begin errors++; $display("FAIL run_prescaler: got %0d expected 0", dut.pre_q); end
    checks++;
    if (bus.index !== 8'd4) begin errors++; $display("FAIL run_index: got %0d expected 4", bus.index); end
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_sequence();
    test_load_handshake();
    test_seed();
    test_back_pressure();
    test_async_reset();
    test_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
